// File: rtl/axi_arb_pkg.sv
// -----------------------------------------------------------------------------
// axi_arb_pkg
//   Shared types and helpers for the AXI4-Lite round-robin grant scheduler.
//   - arb_state_t : per-path arbitration state (idle / address phase / response phase)
//   - rr_pick     : round-robin selection returning a one-hot grant
//   - onehot_idx  : index of the set bit of a one-hot vector
//   Helpers operate on vectors sized for the largest supported master count
//   (MAX_MASTERS); callers zero-extend their narrower request vectors.
// -----------------------------------------------------------------------------
package axi_arb_pkg;

  localparam int unsigned MAX_MASTERS = 8;
  localparam int unsigned IDX_W       = 3;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ADDR = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_t;

  // First set request found searching upward from (last + 1) mod n, wrapping.
  // Only the lower n bits of req are considered. Returns all-zero if none set.
  function automatic logic [MAX_MASTERS-1:0] rr_pick(
    input logic [MAX_MASTERS-1:0] req,
    input logic [IDX_W-1:0]       last,
    input int unsigned            n
  );
    logic [MAX_MASTERS-1:0] pick;
    logic                   found;
    logic [IDX_W-1:0]       idx;
    int unsigned            pos;
    pick  = '0;
    found = 1'b0;
    for (int unsigned i = 1; i <= MAX_MASTERS; i++) begin
      // last < n and i <= n, so a single conditional subtract is a full modulo.
      pos = 32'(last) + i;
      if (pos >= n) begin
        pos = pos - n;
      end
      idx = IDX_W'(pos);
      if ((i <= n) && !found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
    return pick;
  endfunction

  // Index of the set bit of a one-hot vector (0 when the vector is empty).
  function automatic logic [IDX_W-1:0] onehot_idx(
    input logic [MAX_MASTERS-1:0] oh
  );
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < MAX_MASTERS; i++) begin
      if (oh[i]) begin
        idx = IDX_W'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter_path.sv
// -----------------------------------------------------------------------------
// rr_arbiter_path
//   One arbitration path (write or read) of the shared AXI4-Lite slave port.
//   Grants one requester per transaction, holds the grant from the address
//   handshake through the response handshake, and force-releases a grant that
//   has made no progress for TIMEOUT_CYCLES cycles.
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   req       in   [NUM_MASTERS] per-master request (sampled only while idle)
//   addr_hs   in   address-channel handshake on the shared port (AW or AR)
//   resp_hs   in   response-channel handshake on the shared port (B or R)
//   grant     out  [NUM_MASTERS] one-hot owner, all-zero while idle
//   timeout   out  1-cycle pulse coincident with a forced release
// -----------------------------------------------------------------------------
module rr_arbiter_path
  import axi_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS    = 3,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned CNT_WIDTH      = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_MASTERS-1:0] req,
  input  logic                   addr_hs,
  input  logic                   resp_hs,
  output logic [NUM_MASTERS-1:0] grant,
  output logic                   timeout
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0]     LAST_RST = IDX_W'(NUM_MASTERS - 1);

  arb_state_t             state_q,   state_d;
  logic [NUM_MASTERS-1:0] grant_q,   grant_d;
  logic [IDX_W-1:0]       last_q,    last_d;
  logic [CNT_WIDTH-1:0]   cnt_q,     cnt_d;
  logic                   timeout_q, timeout_d;

  logic [MAX_MASTERS-1:0] req_ext;
  logic [MAX_MASTERS-1:0] grant_ext;
  logic [MAX_MASTERS-1:0] pick_ext;
  logic [IDX_W-1:0]       owner_idx;
  logic                   expire;

  // Widen to the helper width; unused upper masters never request.
  always_comb begin
    req_ext                    = '0;
    req_ext[NUM_MASTERS-1:0]   = req;
    grant_ext                  = '0;
    grant_ext[NUM_MASTERS-1:0] = grant_q;
  end

  assign pick_ext  = rr_pick(req_ext, last_q, NUM_MASTERS);
  assign owner_idx = onehot_idx(grant_ext);

  // The cycle holding CNT_LAST is the TIMEOUT_CYCLES-th cycle without progress;
  // its edge is where the counter would reach TIMEOUT_CYCLES.
  assign expire = (cnt_q == CNT_LAST);

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;

    unique case (state_q)
      ARB_IDLE: begin
        // Handshakes are ignored here; only a request starts a transaction.
        if (|req) begin
          grant_d = pick_ext[NUM_MASTERS-1:0];
          state_d = ARB_ADDR;
          cnt_d   = '0;
        end
      end

      ARB_ADDR: begin
        if (resp_hs) begin
          // Response with (or without) the address handshake: transaction over.
          // A lone response here is a protocol error but is treated as done.
          state_d = ARB_IDLE;
          grant_d = '0;
          last_d  = owner_idx;
          cnt_d   = '0;
        end else if (addr_hs) begin
          state_d = ARB_RESP;
          cnt_d   = '0;
        end else if (expire) begin
          state_d   = ARB_IDLE;
          grant_d   = '0;
          last_d    = owner_idx;
          cnt_d     = '0;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end

      ARB_RESP: begin
        // Completion is checked first so a response on the expiry cycle wins.
        if (resp_hs) begin
          state_d = ARB_IDLE;
          grant_d = '0;
          last_d  = owner_idx;
          cnt_d   = '0;
        end else if (expire) begin
          state_d   = ARB_IDLE;
          grant_d   = '0;
          last_d    = owner_idx;
          cnt_d     = '0;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end

      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ARB_IDLE;
      grant_q   <= '0;
      last_q    <= LAST_RST;   // master 0 searched first after reset
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant   = grant_q;
  assign timeout = timeout_q;

endmodule

// File: rtl/axi_lite_rr_scheduler.sv
// -----------------------------------------------------------------------------
// axi_lite_rr_scheduler
//   Grant scheduler sharing one AXI4-Lite slave port between NUM_MASTERS
//   requesters. The write path (AW/W/B) and read path (AR/R) are arbitrated
//   independently; each grant vector steers the bus block's channel muxes.
//
// Ports
//   axi_aclk     in   clock, all logic rising-edge
//   axi_aresetn  in   asynchronous active-low reset
//   wr_req       in   [NUM_MASTERS] per-master AW valid
//   rd_req       in   [NUM_MASTERS] per-master AR valid
//   aw_hs, b_hs  in   write address / write response handshakes on shared port
//   ar_hs, r_hs  in   read address / read data handshakes on shared port
//   wr_grant     out  [NUM_MASTERS] one-hot write owner (0 when idle)
//   rd_grant     out  [NUM_MASTERS] one-hot read owner (0 when idle)
//   wr_busy      out  write path owned
//   rd_busy      out  read path owned
//   wr_timeout   out  1-cycle pulse on forced write release
//   rd_timeout   out  1-cycle pulse on forced read release
// -----------------------------------------------------------------------------
module axi_lite_rr_scheduler
  import axi_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS    = 3,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned CNT_WIDTH      = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                   axi_aclk,
  input  logic                   axi_aresetn,
  input  logic [NUM_MASTERS-1:0] wr_req,
  input  logic [NUM_MASTERS-1:0] rd_req,
  input  logic                   aw_hs,
  input  logic                   b_hs,
  input  logic                   ar_hs,
  input  logic                   r_hs,
  output logic [NUM_MASTERS-1:0] wr_grant,
  output logic [NUM_MASTERS-1:0] rd_grant,
  output logic                   wr_busy,
  output logic                   rd_busy,
  output logic                   wr_timeout,
  output logic                   rd_timeout
);

  localparam int unsigned NUM_PATHS = 2;   // index 0 = write, 1 = read

  logic [NUM_MASTERS-1:0] path_req     [NUM_PATHS];
  logic [NUM_MASTERS-1:0] path_grant   [NUM_PATHS];
  logic                   path_addr_hs [NUM_PATHS];
  logic                   path_resp_hs [NUM_PATHS];
  logic                   path_timeout [NUM_PATHS];

  assign path_req[0]     = wr_req;
  assign path_addr_hs[0] = aw_hs;
  assign path_resp_hs[0] = b_hs;
  assign path_req[1]     = rd_req;
  assign path_addr_hs[1] = ar_hs;
  assign path_resp_hs[1] = r_hs;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PATHS; gi++) begin : g_path
      rr_arbiter_path #(
        .NUM_MASTERS    (NUM_MASTERS),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_WIDTH      (CNT_WIDTH)
      ) u_path (
        .clk     (axi_aclk),
        .rst_n   (axi_aresetn),
        .req     (path_req[gi]),
        .addr_hs (path_addr_hs[gi]),
        .resp_hs (path_resp_hs[gi]),
        .grant   (path_grant[gi]),
        .timeout (path_timeout[gi])
      );
    end
  endgenerate

  assign wr_grant   = path_grant[0];
  assign rd_grant   = path_grant[1];
  assign wr_busy    = |path_grant[0];
  assign rd_busy    = |path_grant[1];
  assign wr_timeout = path_timeout[0];
  assign rd_timeout = path_timeout[1];

endmodule

// File: tb/tb_axi_lite_rr_scheduler.sv
// -----------------------------------------------------------------------------
// tb_axi_lite_rr_scheduler
//   Directed scenarios plus a randomized run, all checked against a
//   transaction-level reference model of each arbitration path.
// -----------------------------------------------------------------------------
module tb_axi_lite_rr_scheduler;

  localparam int N = 3;
  localparam int T = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] wr_req, rd_req;
  logic         aw_hs, b_hs, ar_hs, r_hs;
  logic [N-1:0] wr_grant, rd_grant;
  logic         wr_busy, rd_busy, wr_timeout, rd_timeout;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: per path (0 = write, 1 = read)
  int m_owner [2];   // -1 when idle
  int m_phase [2];   // 0 = waiting address handshake, 1 = waiting response
  int m_age   [2];   // cycles held since grant or last address handshake
  int m_last  [2];   // previous owner
  bit m_to    [2];   // forced-release pulse

  always #5 clk = ~clk;

  axi_lite_rr_scheduler #(
    .NUM_MASTERS    (N),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .axi_aclk    (clk),
    .axi_aresetn (rst_n),
    .wr_req      (wr_req),
    .rd_req      (rd_req),
    .aw_hs       (aw_hs),
    .b_hs        (b_hs),
    .ar_hs       (ar_hs),
    .r_hs        (r_hs),
    .wr_grant    (wr_grant),
    .rd_grant    (rd_grant),
    .wr_busy     (wr_busy),
    .rd_busy     (rd_busy),
    .wr_timeout  (wr_timeout),
    .rd_timeout  (rd_timeout)
  );

  function automatic void model_reset();
    for (int p = 0; p < 2; p++) begin
      m_owner[p] = -1;
      m_phase[p] = 0;
      m_age[p]   = 0;
      m_last[p]  = N - 1;
      m_to[p]    = 1'b0;
    end
  endfunction

  function automatic int rr_first(logic [N-1:0] req, int last);
    for (int i = 1; i <= N; i++) begin
      int idx;
      idx = (last + i) % N;
      if (((req >> idx) & N'(1)) != '0) return idx;
    end
    return -1;
  endfunction

  // Advance one path by one clock given the inputs present before the edge.
  function automatic void model_path(int p, logic [N-1:0] req, bit xhs, bit yhs);
    m_to[p] = 1'b0;
    if (m_owner[p] < 0) begin
      if (req != '0) begin
        m_owner[p] = rr_first(req, m_last[p]);
        m_phase[p] = 0;
        m_age[p]   = 0;
      end
    end else begin
      m_age[p] = m_age[p] + 1;
      if (yhs) begin
        m_last[p]  = m_owner[p];
        m_owner[p] = -1;
      end else if (m_phase[p] == 0 && xhs) begin
        m_phase[p] = 1;
        m_age[p]   = 0;
      end else if (m_age[p] >= T) begin
        m_last[p]  = m_owner[p];
        m_owner[p] = -1;
        m_to[p]    = 1'b1;
      end
    end
  endfunction

  function automatic logic [N-1:0] exp_grant(int p);
    if (m_owner[p] < 0) return '0;
    return N'(1) << m_owner[p];
  endfunction

  task automatic tick();
    model_path(0, wr_req, aw_hs, b_hs);
    model_path(1, rd_req, ar_hs, r_hs);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_req = '0; rd_req = '0;
    aw_hs = 1'b0; b_hs = 1'b0; ar_hs = 1'b0; r_hs = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    #2;
    vectors++;
    if ({wr_grant, rd_grant, wr_busy, rd_busy, wr_timeout, rd_timeout} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs got=%b/%b/%b%b%b%b required=all zero",
               wr_grant, rd_grant, wr_busy, rd_busy, wr_timeout, rd_timeout);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    vectors++;
    if (wr_grant !== '0 || rd_grant !== '0) begin
      miscompares++;
      $display("FAIL reset_idle got wr=%b rd=%b required 000/000", wr_grant, rd_grant);
    end
  endtask

  task automatic test_rotation();
    logic [N-1:0] want;
    wr_req = 3'b111;
    for (int k = 0; k < N; k++) begin
      want = N'(1) << k;
      tick();
      vectors++;
      if (wr_grant !== want || wr_grant !== exp_grant(0) || wr_busy !== 1'b1) begin
        miscompares++;
        $display("FAIL rotation_grant[%0d] got=%b busy=%b required=%b", k, wr_grant, wr_busy, want);
      end
      aw_hs = 1'b1; tick(); aw_hs = 1'b0;
      vectors++;
      if (wr_grant !== want) begin
        miscompares++;
        $display("FAIL rotation_hold_resp[%0d] got=%b required=%b", k, wr_grant, want);
      end
      b_hs = 1'b1; tick(); b_hs = 1'b0;
      vectors++;
      if (wr_grant !== '0 || wr_busy !== 1'b0) begin
        miscompares++;
        $display("FAIL rotation_idle_bubble[%0d] got=%b busy=%b required=000", k, wr_grant, wr_busy);
      end
    end
    wr_req = '0;
    tick();
  endtask

  task automatic test_same_cycle_done();
    wr_req = 3'b111;
    tick();                                   // owner 0
    aw_hs = 1'b1; b_hs = 1'b1; tick(); aw_hs = 1'b0; b_hs = 1'b0;
    tick();                                   // owner 1
    vectors++;
    if (wr_grant !== 3'b010) begin
      miscompares++;
      $display("FAIL same_cycle_owner1 got=%b required=010", wr_grant);
    end
    aw_hs = 1'b1; b_hs = 1'b1; tick(); aw_hs = 1'b0; b_hs = 1'b0;
    vectors++;
    if (wr_grant !== 3'b000 || wr_timeout !== 1'b0 || wr_grant !== exp_grant(0)) begin
      miscompares++;
      $display("FAIL same_cycle_release got=%b to=%b required=000 to=0", wr_grant, wr_timeout);
    end
    tick();
    vectors++;
    if (wr_grant !== 3'b100) begin
      miscompares++;
      $display("FAIL same_cycle_next got=%b required=100", wr_grant);
    end
    aw_hs = 1'b1; b_hs = 1'b1; tick(); aw_hs = 1'b0; b_hs = 1'b0;
    wr_req = '0;
    tick();
  endtask

  task automatic test_timeout();
    wr_req = 3'b001;
    tick();
    wr_req = 3'b011;
    for (int c = 1; c < T; c++) begin
      tick();
      vectors++;
      if (wr_grant !== 3'b001 || wr_timeout !== 1'b0) begin
        miscompares++;
        $display("FAIL timeout_hold[%0d] got=%b to=%b required=001 to=0", c, wr_grant, wr_timeout);
      end
    end
    tick();
    vectors++;
    if (wr_grant !== 3'b000 || wr_timeout !== 1'b1 || wr_timeout !== m_to[0]) begin
      miscompares++;
      $display("FAIL timeout_release got=%b to=%b required=000 to=1", wr_grant, wr_timeout);
    end
    tick();
    vectors++;
    if (wr_grant !== 3'b010 || wr_timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_next got=%b to=%b required=010 to=0", wr_grant, wr_timeout);
    end
    aw_hs = 1'b1; tick(); aw_hs = 1'b0;
    b_hs = 1'b1; tick(); b_hs = 1'b0;
    wr_req = '0;
    tick();
  endtask

  task automatic test_complete_at_expiry();
    wr_req = 3'b100;
    tick();
    vectors++;
    if (wr_grant !== 3'b100) begin
      miscompares++;
      $display("FAIL expiry_grant got=%b required=100", wr_grant);
    end
    aw_hs = 1'b1; tick(); aw_hs = 1'b0;
    wr_req = '0;
    for (int c = 1; c < T; c++) tick();
    b_hs = 1'b1; tick(); b_hs = 1'b0;
    vectors++;
    if (wr_grant !== 3'b000 || wr_timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL expiry_completion_wins got=%b to=%b required=000 to=0", wr_grant, wr_timeout);
    end
    tick();
    vectors++;
    if (wr_timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL expiry_no_late_pulse got=%b required=0", wr_timeout);
    end
  endtask

  task automatic test_dual_path();
    wr_req = 3'b001; rd_req = 3'b001;
    tick();
    vectors++;
    if (wr_grant !== 3'b001 || rd_grant !== 3'b001 || !wr_busy || !rd_busy) begin
      miscompares++;
      $display("FAIL dual_same_cycle got wr=%b rd=%b required 001/001", wr_grant, rd_grant);
    end
    wr_req = '0; rd_req = '0;
    aw_hs = 1'b1; b_hs = 1'b1; tick(); aw_hs = 1'b0; b_hs = 1'b0;
    vectors++;
    if (wr_grant !== 3'b000 || rd_grant !== 3'b001) begin
      miscompares++;
      $display("FAIL dual_independent got wr=%b rd=%b required 000/001", wr_grant, rd_grant);
    end
    ar_hs = 1'b1; tick(); ar_hs = 1'b0;
    r_hs = 1'b1; tick(); r_hs = 1'b0;
    vectors++;
    if (rd_grant !== 3'b000 || rd_grant !== exp_grant(1)) begin
      miscompares++;
      $display("FAIL dual_read_done got=%b required=000", rd_grant);
    end
  endtask

  task automatic test_async_reset();
    wr_req = 3'b100; rd_req = 3'b100;
    tick();
    aw_hs = 1'b1; ar_hs = 1'b1; tick(); aw_hs = 1'b0; ar_hs = 1'b0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    vectors++;
    if (wr_grant !== '0 || rd_grant !== '0 || wr_busy || rd_busy) begin
      miscompares++;
      $display("FAIL async_reset_drop got wr=%b rd=%b required 000/000", wr_grant, rd_grant);
    end
    idle_inputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    rd_req = 3'b010;
    tick();
    vectors++;
    if (rd_grant !== 3'b010 || rd_grant !== exp_grant(1) || wr_grant !== 3'b000) begin
      miscompares++;
      $display("FAIL async_reset_regrant got rd=%b wr=%b required 010/000", rd_grant, wr_grant);
    end
    ar_hs = 1'b1; r_hs = 1'b1; tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) wr_req = N'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) rd_req = N'($urandom_range(0, 7));
      aw_hs = ($urandom_range(0, 99) < 15);
      b_hs  = ($urandom_range(0, 99) < 12);
      ar_hs = ($urandom_range(0, 99) < 15);
      r_hs  = ($urandom_range(0, 99) < 12);
      tick();
      vectors++;
      if (wr_grant !== exp_grant(0) || wr_busy !== (m_owner[0] >= 0) || wr_timeout !== m_to[0]) begin
        miscompares++;
        $display("FAIL random_wr[%0d] got g=%b b=%b t=%b required g=%b b=%b t=%b", i,
                 wr_grant, wr_busy, wr_timeout, exp_grant(0), (m_owner[0] >= 0), m_to[0]);
      end
      vectors++;
      if (rd_grant !== exp_grant(1) || rd_busy !== (m_owner[1] >= 0) || rd_timeout !== m_to[1]) begin
        miscompares++;
        $display("FAIL random_rd[%0d] got g=%b b=%b t=%b required g=%b b=%b t=%b", i,
                 rd_grant, rd_busy, rd_timeout, exp_grant(1), (m_owner[1] >= 0), m_to[1]);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_same_cycle_done();
    test_timeout();
    test_complete_at_expiry();
    test_dual_path();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
